// File: rtl/qar_can_tx_framer.sv
// CAN 2.0A standard data-frame transmitter. It serialises the latched frame fields one bit per
// bit_tick, inserting stuff bits, appending CRC-15, arbitrating on the ID/RTR bits and checking the ACK slot.
module qar_can_tx_framer #(
  parameter int EOF_BITS = 7,
  parameter int IFS_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_tick,
  input  logic        start,
  input  logic        abort,
  input  logic [10:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [31:0] tx_data0,
  input  logic [31:0] tx_data1,
  input  logic        can_rx,
  output logic        can_tx,
  output logic        busy,
  output logic        done,
  output logic        arb_lost,
  output logic        ack_err
);

  // ST_START: the frame is accepted but nothing is on the wire yet.
  // Every other state names the field of the last non-stuff bit that was driven.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_SOF,
    ST_ID,
    ST_RTR,
    ST_IDE,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_stuff, w_stuff_nxt;
  logic [2:0]  r_run, w_run_nxt;
  logic [14:0] r_crc, w_crc_nxt;
  logic [10:0] r_id, w_id_nxt;
  logic [3:0]  r_dlc, w_dlc_nxt;
  logic [63:0] r_data, w_data_nxt;
  logic        r_done, w_done_nxt;
  logic        r_arb, w_arb_nxt;
  logic        r_ack, w_ack_nxt;

  logic        w_bit;
  logic        w_crc_en;
  logic [3:0]  w_nbytes;
  logic [5:0]  w_data_last;
  logic        w_in_stuff_field;
  logic        w_need_stuff;
  logic        w_arb_loss;
  logic        w_ack_miss;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  assign w_nbytes    = (r_dlc > 4'd8) ? 4'd8 : r_dlc;
  assign w_data_last = 6'({w_nbytes, 3'b000} - 7'd1);

  assign w_in_stuff_field = (r_state == ST_SOF) || (r_state == ST_ID)  || (r_state == ST_RTR) ||
                            (r_state == ST_IDE) || (r_state == ST_R0)  || (r_state == ST_DLC) ||
                            (r_state == ST_DATA) || (r_state == ST_CRC);
  assign w_need_stuff = w_in_stuff_field && (r_run == 3'd5);

  // The checks look at the bit currently on can_tx; stuff bits never arbitrate.
  assign w_arb_loss = ((r_state == ST_ID) || (r_state == ST_RTR)) && !r_stuff && r_tx && !can_rx;
  assign w_ack_miss = (r_state == ST_ACK_SLOT) && can_rx;

  // start is a request qualified by busy: it is taken only on a clk where busy=0 and abort=0,
  // and busy rises on the following clk; every other start is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_stuff_nxt = r_stuff;
    w_run_nxt   = r_run;
    w_crc_nxt   = r_crc;
    w_id_nxt    = r_id;
    w_dlc_nxt   = r_dlc;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_arb_nxt   = 1'b0;
    w_ack_nxt   = 1'b0;
    w_bit       = 1'b1;
    w_crc_en    = 1'b0;

    if (r_state == ST_IDLE) begin
      if (start && !abort) begin
        w_state_nxt = ST_START;
        w_busy_nxt  = 1'b1;
        w_cnt_nxt   = '0;
        w_stuff_nxt = 1'b0;
        w_run_nxt   = '0;
        w_crc_nxt   = '0;
        w_id_nxt    = tx_id;
        w_dlc_nxt   = tx_dlc;
        w_data_nxt  = {tx_data0[7:0], tx_data0[15:8], tx_data0[23:16], tx_data0[31:24],
                       tx_data1[7:0], tx_data1[15:8], tx_data1[23:16], tx_data1[31:24]};
      end
    end else if (abort) begin
      w_state_nxt = ST_IDLE;
      w_tx_nxt    = 1'b1;
      w_busy_nxt  = 1'b0;
    end else if (bit_tick) begin
      if (w_arb_loss) begin
        w_arb_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end else if (w_ack_miss) begin
        w_ack_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end else if (w_need_stuff) begin
        w_tx_nxt    = ~r_tx;
        w_stuff_nxt = 1'b1;
        w_run_nxt   = 3'd1;
      end else begin
        w_stuff_nxt = 1'b0;
        case (r_state)
          ST_START: begin
            w_state_nxt = ST_SOF;
            w_bit       = 1'b0;
            w_crc_en    = 1'b1;
          end
          ST_SOF: begin
            w_state_nxt = ST_ID;
            w_cnt_nxt   = 6'd10;
            w_bit       = r_id[10];
            w_crc_en    = 1'b1;
          end
          ST_ID: begin
            w_crc_en = 1'b1;
            if (r_cnt != 6'd0) begin
              w_cnt_nxt = r_cnt - 6'd1;
              w_bit     = r_id[4'(r_cnt - 6'd1)];
            end else begin
              w_state_nxt = ST_RTR;
              w_bit       = 1'b0;
            end
          end
          ST_RTR: begin
            w_state_nxt = ST_IDE;
            w_bit       = 1'b0;
            w_crc_en    = 1'b1;
          end
          ST_IDE: begin
            w_state_nxt = ST_R0;
            w_bit       = 1'b0;
            w_crc_en    = 1'b1;
          end
          ST_R0: begin
            w_state_nxt = ST_DLC;
            w_cnt_nxt   = 6'd3;
            w_bit       = r_dlc[3];
            w_crc_en    = 1'b1;
          end
          ST_DLC: begin
            if (r_cnt != 6'd0) begin
              w_cnt_nxt = r_cnt - 6'd1;
              w_bit     = r_dlc[2'(r_cnt - 6'd1)];
              w_crc_en  = 1'b1;
            end else if (w_nbytes == 4'd0) begin
              w_state_nxt = ST_CRC;
              w_cnt_nxt   = 6'd14;
              w_bit       = r_crc[14];
              w_crc_nxt   = {r_crc[13:0], 1'b0};
            end else begin
              w_state_nxt = ST_DATA;
              w_cnt_nxt   = w_data_last;
              w_bit       = r_data[63];
              w_data_nxt  = {r_data[62:0], 1'b0};
              w_crc_en    = 1'b1;
            end
          end
          ST_DATA: begin
            if (r_cnt != 6'd0) begin
              w_cnt_nxt  = r_cnt - 6'd1;
              w_bit      = r_data[63];
              w_data_nxt = {r_data[62:0], 1'b0};
              w_crc_en   = 1'b1;
            end else begin
              w_state_nxt = ST_CRC;
              w_cnt_nxt   = 6'd14;
              w_bit       = r_crc[14];
              w_crc_nxt   = {r_crc[13:0], 1'b0};
            end
          end
          ST_CRC: begin
            if (r_cnt != 6'd0) begin
              w_cnt_nxt = r_cnt - 6'd1;
              w_bit     = r_crc[14];
              w_crc_nxt = {r_crc[13:0], 1'b0};
            end else begin
              w_state_nxt = ST_CRC_DEL;
            end
          end
          ST_CRC_DEL: w_state_nxt = ST_ACK_SLOT;
          ST_ACK_SLOT: w_state_nxt = ST_ACK_DEL;
          ST_ACK_DEL: begin
            w_state_nxt = ST_EOF;
            w_cnt_nxt   = 6'(EOF_BITS - 1);
          end
          ST_EOF: begin
            if (r_cnt != 6'd0) begin
              w_cnt_nxt = r_cnt - 6'd1;
            end else begin
              w_state_nxt = ST_IFS;
              w_cnt_nxt   = 6'(IFS_BITS - 1);
            end
          end
          ST_IFS: begin
            if (r_cnt != 6'd0) begin
              w_cnt_nxt = r_cnt - 6'd1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        endcase
        w_tx_nxt  = w_bit;
        w_run_nxt = (w_bit == r_tx) ? r_run + 3'd1 : 3'd1;
        if (w_crc_en) begin
          w_crc_nxt = crc15_step(r_crc, w_bit);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_stuff <= 1'b0;
      r_run   <= '0;
      r_crc   <= '0;
      r_id    <= '0;
      r_dlc   <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_arb   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_stuff <= w_stuff_nxt;
      r_run   <= w_run_nxt;
      r_crc   <= w_crc_nxt;
      r_id    <= w_id_nxt;
      r_dlc   <= w_dlc_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_arb   <= w_arb_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign can_tx   = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign arb_lost = r_arb;
  assign ack_err  = r_ack;

endmodule

// File: tb/tb_qar_can_tx_framer.sv
// Bench for qar_can_tx_framer: randomized frames compared bit by bit against a queue-built
// reference frame (field list -> CRC -> stuffing), plus arbitration, ACK, abort and reset cases.
module tb_qar_can_tx_framer;

  localparam int EOF_BITS = 7;
  localparam int IFS_BITS = 3;

  logic        clk;
  logic        rst_n;
  logic        bit_tick;
  logic        start;
  logic        abort;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [31:0] tx_data0;
  logic [31:0] tx_data1;
  logic        can_rx;
  logic        can_tx;
  logic        busy;
  logic        done;
  logic        arb_lost;
  logic        ack_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected frame, one entry per driven bit: {ack_slot, data, arbitration, value}.
  logic [3:0] exp_q[$];

  qar_can_tx_framer #(.EOF_BITS(EOF_BITS), .IFS_BITS(IFS_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .start(start), .abort(abort),
    .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data0(tx_data0), .tx_data1(tx_data1),
    .can_rx(can_rx), .can_tx(can_tx), .busy(busy), .done(done),
    .arb_lost(arb_lost), .ack_err(ack_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference frame: unstuffed field list, CRC over it, then the stuffing rule and the fixed tail.
  task automatic build_frame(input logic [10:0] id, input logic [3:0] dlc,
                             input logic [31:0] d0, input logic [31:0] d1);
    logic [2:0]  raw_q[$];
    logic [14:0] crc;
    logic [7:0]  byte_v;
    logic        last, fb;
    int          nb, run;
    raw_q = {};
    raw_q.push_back(3'b000);
    for (int i = 10; i >= 0; i--) raw_q.push_back({2'b01, id[i]});
    raw_q.push_back(3'b010);
    raw_q.push_back(3'b000);
    raw_q.push_back(3'b000);
    for (int i = 3; i >= 0; i--) raw_q.push_back({2'b00, dlc[i]});
    nb = (dlc > 4'd8) ? 8 : int'(dlc);
    for (int b = 0; b < nb; b++) begin
      byte_v = (b < 4) ? d0[8*b +: 8] : d1[8*(b-4) +: 8];
      for (int i = 7; i >= 0; i--) raw_q.push_back({2'b10, byte_v[i]});
    end
    crc = '0;
    foreach (raw_q[j]) begin
      fb  = raw_q[j][0] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) raw_q.push_back({2'b00, crc[i]});
    exp_q = {};
    run  = 0;
    last = 1'b1;
    foreach (raw_q[j]) begin
      exp_q.push_back({1'b0, raw_q[j]});
      if (raw_q[j][0] == last) run++;
      else run = 1;
      last = raw_q[j][0];
      if (run == 5) begin
        exp_q.push_back({3'b000, ~last});
        last = ~last;
        run  = 1;
      end
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0001);
    repeat (EOF_BITS + IFS_BITS) exp_q.push_back(4'b0001);
  endtask

  // mode: 0 loopback + ACK, 1 loopback no ACK, 2 bus held dominant, 3 loopback + ACK + one forced
  // dominant on a recessive ID bit. stop_kind: 0 none, 1 abort, 2 reset, at the stop_nth zero data bit.
  // end_kind: 0 done, 1 arb_lost, 2 ack_err, 3 stopped.
  task automatic run_frame(input logic [10:0] id, input logic [3:0] dlc,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int mode, input int stop_kind, input int stop_nth,
                           output int end_tick, output int end_kind);
    int         n, tgt, stop_tick, cnt, g;
    int         cand[$];
    logic       rx, lost, aerr, tx_snap;
    logic [3:0] prev;
    build_frame(id, dlc, d0, d1);
    n = exp_q.size();
    tgt = -1;
    cand = {};
    foreach (exp_q[j]) if (exp_q[j][1] && exp_q[j][0]) cand.push_back(j);
    if (mode == 3 && cand.size() > 0) tgt = cand[$urandom_range(0, cand.size() - 1)];
    stop_tick = -1;
    cnt = 0;
    if (stop_kind != 0) begin
      foreach (exp_q[j]) begin
        if (exp_q[j][2] && !exp_q[j][0]) begin
          cnt++;
          if (cnt == stop_nth && stop_tick < 0) stop_tick = j + 1;
        end
      end
    end
    end_tick = -1;
    end_kind = -1;

    @(negedge clk);
    tx_id = id; tx_dlc = dlc; tx_data0 = d0; tx_data1 = d1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_tx", can_tx, 1);
    prev    = 4'b0001;
    tx_snap = 1'b1;
    for (int k = 1; k <= n + 1; k++) begin
      g = $urandom_range(0, 3);
      repeat (g) @(posedge clk);
      @(negedge clk);
      check("hold_tx", can_tx, tx_snap);
      case (mode)
        0:       rx = prev[3] ? 1'b0 : prev[0];
        1:       rx = prev[0];
        2:       rx = 1'b0;
        default: rx = (k - 2 == tgt) ? 1'b0 : (prev[3] ? 1'b0 : prev[0]);
      endcase
      lost = prev[1] & prev[0] & ~rx;
      aerr = prev[3] & rx;
      can_rx   = rx;
      bit_tick = 1'b1;
      start    = ($urandom_range(0, 7) == 0);
      tx_id    = 11'($urandom);
      tx_dlc   = 4'($urandom);
      tx_data0 = $urandom;
      tx_data1 = $urandom;
      @(posedge clk); #1;
      bit_tick = 1'b0;
      start    = 1'b0;
      tx_snap  = can_tx;
      if (lost || aerr || k == n + 1) begin
        end_tick = k;
        end_kind = lost ? 1 : (aerr ? 2 : 0);
        check("end_pulses", {done, arb_lost, ack_err}, lost ? 3'b010 : (aerr ? 3'b001 : 3'b100));
        check("end_busy", busy, 0);
        check("end_tx", can_tx, 1);
        break;
      end
      check("frame_bit", can_tx, exp_q[k-1][0]);
      check("frame_flags", {busy, done, arb_lost, ack_err}, 4'b1000);
      if (k == stop_tick && stop_kind == 1) begin
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_state", {can_tx, busy, done, arb_lost, ack_err}, 5'b10000);
        end_tick = k;
        end_kind = 3;
        break;
      end
      if (k == stop_tick && stop_kind == 2) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", {can_tx, busy, done, arb_lost, ack_err}, 5'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        end_tick = k;
        end_kind = 3;
        break;
      end
      prev = exp_q[k-1];
    end
    if (end_kind != 3) begin
      repeat (3) @(posedge clk);
      #1;
      check("after_idle", {can_tx, busy, done, arb_lost, ack_err}, 5'b10000);
    end
  endtask

  int et, ek, md;

  initial begin
    rst_n = 1'b0; bit_tick = 1'b0; start = 1'b0; abort = 1'b0;
    tx_id = '0; tx_dlc = '0; tx_data0 = '0; tx_data1 = '0; can_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {can_tx, busy, done, arb_lost, ack_err}, 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;

    // bit_tick while idle, then abort+start together in idle
    repeat (3) begin
      @(negedge clk);
      bit_tick = 1'b1;
      @(posedge clk); #1;
      bit_tick = 1'b0;
      check("idle_tick", {can_tx, busy, done, arb_lost, ack_err}, 5'b10000);
    end
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", busy, 0);

    run_frame(11'h000, 4'd0, 32'h0, 32'h0, 0, 0, 0, et, ek);
    check("zero_done_kind", ek, 0);
    check("zero_done_tick", et, 54);

    run_frame(11'h000, 4'd0, 32'h0, 32'h0, 1, 0, 0, et, ek);
    check("noack_kind", ek, 2);
    check("noack_tick", et, 43);

    run_frame(11'h7FF, 4'($urandom), $urandom, $urandom, 2, 0, 0, et, ek);
    check("arb_kind", ek, 1);
    check("arb_tick", et, 3);

    run_frame(11'h123, 4'd8, 32'h44332211, 32'h88776655, 0, 0, 0, et, ek);
    check("d8_kind", ek, 0);
    check("d8_tick", et, exp_q.size() + 1);

    run_frame(11'($urandom), 4'd15, $urandom, $urandom, 0, 0, 0, et, ek);
    check("dlc15_kind", ek, 0);
    check("dlc15_tick", et, exp_q.size() + 1);

    for (int i = 0; i < 12; i++) begin
      md = (i % 3 == 0) ? 3 : ((i % 5 == 4) ? 1 : 0);
      run_frame(11'($urandom), 4'($urandom), $urandom, $urandom, md, 0, 0, et, ek);
      check("rand_kind", ek, (md == 1) ? 2 : ((md == 3) ? 1 : 0));
    end

    run_frame(11'h2A5, 4'd4, 32'h44332211, 32'h0, 0, 1, 3, et, ek);
    check("abort_kind", ek, 3);
    run_frame(11'($urandom), 4'($urandom), $urandom, $urandom, 0, 0, 0, et, ek);
    check("after_abort_kind", ek, 0);

    run_frame(11'h155, 4'd2, 32'h00002211, 32'h0, 0, 2, 5, et, ek);
    check("reset_kind", ek, 3);
    run_frame(11'($urandom), 4'($urandom), $urandom, $urandom, 0, 0, 0, et, ek);
    check("after_reset_kind", ek, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
